// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, handler vector, exception codes, field positions.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package cp0_exc_ctrl_pkg;

  localparam int CP0_HW_INT_W = 6;

  // CP0 register numbers served by mfc0/mtc0
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Fixed handler entry point used by the next-PC block when pc_to_in is high
  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Field positions inside SR and Cause
  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD_BIT  = 31;

  // EPC is always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] v);
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_int_arb.sv
// Combinational arbitration between interrupts, exceptions and ERET.
// Latency: zero, outputs follow inputs in the same cycle.
// Backpressure: none; EXL masks all new requests while the handler runs.
module cp0_int_arb
  import cp0_exc_ctrl_pkg::*;
#(
  parameter int HW_INT_W = CP0_HW_INT_W
) (
  input  logic                reset,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic [HW_INT_W-1:0] im,
  input  logic                ie,
  input  logic                exl,
  input  logic [4:0]          exc_code,
  input  logic                eret,
  output logic                int_req,
  output logic                exc_req,
  output logic                pc_to_in,
  output logic                pc_back
);

  // Entry beats ERET; reset silences both redirects
  always_comb begin
    int_req  = (|(hw_int & im)) & ie & ~exl;
    exc_req  = (exc_code != 5'd0) & ~exl;
    pc_to_in = ~reset & (int_req | exc_req);
    pc_back  = ~reset & eret & ~(int_req | exc_req);
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: owns SR/Cause/EPC/PRId, drives redirect to handler or EPC.
// Latency: redirect requests and mfc0 reads are combinational; register updates on next edge.
// Backpressure: none; while EXL is set new interrupts/exceptions are dropped, not queued.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h1234_5678,
  parameter int          HW_INT_W = CP0_HW_INT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [4:0]          addr,
  input  logic [31:0]         din,
  output logic [31:0]         dout,
  input  logic [31:0]         pc,
  input  logic                bd,
  input  logic [4:0]          exc_code,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                eret,
  output logic                pc_to_in,
  output logic                pc_back,
  output logic [31:0]         epc
);

  logic [HW_INT_W-1:0] sr_im;
  logic                sr_exl;
  logic                sr_ie;
  logic                cause_bd;
  logic [HW_INT_W-1:0] cause_ip;
  logic [4:0]          cause_exc;
  logic [31:0]         epc_q;

  logic                int_req;
  logic                exc_req;
  logic [31:0]         sr_word;
  logic [31:0]         cause_word;

  cp0_int_arb #(.HW_INT_W(HW_INT_W)) u_arb (
    .reset    (reset),
    .hw_int   (hw_int),
    .im       (sr_im),
    .ie       (sr_ie),
    .exl      (sr_exl),
    .exc_code (exc_code),
    .eret     (eret),
    .int_req  (int_req),
    .exc_req  (exc_req),
    .pc_to_in (pc_to_in),
    .pc_back  (pc_back)
  );

  // CP0 register update: entry overrides mtc0, ERET only clears EXL, IP always samples the lines
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      cause_ip <= hw_int;
      if (pc_to_in) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd;
        cause_exc <= int_req ? EXC_INT : exc_code;
        epc_q     <= bd ? (pc - 32'd4) : pc;
      end else begin
        if (we && addr == CP0_SR) begin
          sr_im  <= din[SR_IM_LSB +: HW_INT_W];
          sr_exl <= din[SR_EXL_BIT];
          sr_ie  <= din[SR_IE_BIT];
        end
        if (we && addr == CP0_EPC) begin
          epc_q <= word_align(din);
        end
        if (pc_back) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  // Assemble architectural register views; unlisted bits read as zero
  always_comb begin
    sr_word                                 = 32'd0;
    sr_word[SR_IM_LSB +: HW_INT_W]          = sr_im;
    sr_word[SR_EXL_BIT]                     = sr_exl;
    sr_word[SR_IE_BIT]                      = sr_ie;
    cause_word                              = 32'd0;
    cause_word[CAUSE_BD_BIT]                = cause_bd;
    cause_word[CAUSE_IP_LSB +: HW_INT_W]    = cause_ip;
    cause_word[CAUSE_EXC_LSB +: 5]          = cause_exc;
  end

  // mfc0 read mux on pre-edge state, forced to zero during reset
  always_comb begin
    dout = 32'd0;
    if (!reset) begin
      case (addr)
        CP0_SR:    dout = sr_word;
        CP0_CAUSE: dout = cause_word;
        CP0_EPC:   dout = epc_q;
        CP0_PRID:  dout = PRID;
        default:   dout = 32'd0;
      endcase
    end
  end

  // Forward an in-flight mtc0 EPC so an ERET in the same slot returns to the new address
  always_comb begin
    epc = epc_q;
    if (we && addr == CP0_EPC) begin
      epc = word_align(din);
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID_VAL = 32'h1234_5678;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        eret;
  logic        pc_to_in;
  logic        pc_back;
  logic [31:0] epc;

  int n_checks = 0;
  int n_errors = 0;

  // reference state: whole architectural register words
  logic [31:0] m_sr, m_cause, m_epc;

  // last observed outputs, for directed literal checks
  logic [31:0] obs_dout, obs_epc;
  logic        obs_to, obs_back;

  cp0_exc_ctrl #(.PRID(PRID_VAL), .HW_INT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .pc       (pc),
    .bd       (bd),
    .exc_code (exc_code),
    .hw_int   (hw_int),
    .eret     (eret),
    .pc_to_in (pc_to_in),
    .pc_back  (pc_back),
    .epc      (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One M-stage slot: drive at negedge, compare combinational outputs, advance model at posedge
  task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] p, input logic b, input logic [4:0] ec,
                      input logic [5:0] hw, input logic er);
    logic        exl, ie, irq, xrq, e_to, e_back;
    logic [31:0] e_epc, e_dout, n_sr, n_cause, n_epc;
    @(negedge clk);
    reset = r; we = w; addr = a; din = d; pc = p; bd = b; exc_code = ec; hw_int = hw; eret = er;
    #1;
    exl    = m_sr[1];
    ie     = m_sr[0];
    irq    = ((hw & m_sr[15:10]) != 6'd0) && ie && !exl;
    xrq    = (ec != 5'd0) && !exl;
    e_to   = !r && (irq || xrq);
    e_back = !r && er && !(irq || xrq);
    e_epc  = (w && a == 5'd14) ? (d & 32'hFFFF_FFFC) : m_epc;
    case (a)
      5'd12:   e_dout = m_sr;
      5'd13:   e_dout = m_cause;
      5'd14:   e_dout = m_epc;
      5'd15:   e_dout = PRID_VAL;
      default: e_dout = 32'd0;
    endcase
    if (r) e_dout = 32'd0;
    obs_to = pc_to_in; obs_back = pc_back; obs_epc = epc; obs_dout = dout;
    check("pc_to_in", {31'd0, pc_to_in}, {31'd0, e_to});
    check("pc_back", {31'd0, pc_back}, {31'd0, e_back});
    check("epc", epc, e_epc);
    check("dout", dout, e_dout);
    n_sr = m_sr; n_epc = m_epc;
    n_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
    if (r) begin
      n_sr = 0; n_cause = 0; n_epc = 0;
    end else if (e_to) begin
      n_sr    = n_sr | 32'h2;
      n_cause = (n_cause & 32'h7FFF_FF83) | ({31'd0, b} << 31) | ({27'd0, (irq ? 5'd0 : ec)} << 2);
      n_epc   = b ? p - 32'd4 : p;
    end else begin
      if (w && a == 5'd12) n_sr = d & 32'h0000_FC03;
      if (w && a == 5'd14) n_epc = d & 32'hFFFF_FFFC;
      if (e_back) n_sr = n_sr & ~32'h2;
    end
    @(posedge clk);
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
  endtask

  // plain read with quiet inputs
  task automatic rd(input logic [4:0] a, input logic [5:0] hw);
    step(0, 0, a, 32'd0, 32'd0, 0, 5'd0, hw, 0);
  endtask

  initial begin
    logic [4:0]  ra, rec;
    logic        rw, rer;
    logic [5:0]  rhw;
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1; we = 0; addr = 0; din = 0; pc = 0; bd = 0; exc_code = 0; hw_int = 0; eret = 0;

    step(1, 0, 5'd12, 0, 0, 0, 5'd0, 6'd0, 0);
    step(1, 0, 5'd15, 0, 0, 0, 5'd0, 6'd0, 0);
    check("rst_dout", obs_dout, 32'd0);

    rd(5'd12, 0); check("rd_sr0", obs_dout, 32'd0);
    rd(5'd13, 0); check("rd_cause0", obs_dout, 32'd0);
    rd(5'd14, 0); check("rd_epc0", obs_dout, 32'd0);
    rd(5'd15, 0); check("rd_prid", obs_dout, PRID_VAL);

    // interrupt entry
    step(0, 1, 5'd12, 32'h0000_FC01, 0, 0, 5'd0, 6'd0, 0);
    step(0, 0, 5'd13, 0, 32'h0000_2000, 0, 5'd0, 6'b000100, 0);
    check("int_entry", {31'd0, obs_to}, 32'd1);
    rd(5'd13, 6'b000100); check("int_cause", obs_dout, 32'h0000_1000);
    rd(5'd12, 6'b000100); check("int_sr", obs_dout, 32'h0000_FC03);
    rd(5'd14, 6'b000100); check("int_epc", obs_dout, 32'h0000_2000);

    // leave handler, then exception in delay slot
    step(0, 0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 1);
    check("eret1", {31'd0, obs_back}, 32'd1);
    step(0, 0, 5'd0, 0, 32'h0000_3010, 1, 5'd12, 6'd0, 0);
    check("exc_entry", {31'd0, obs_to}, 32'd1);
    rd(5'd14, 0); check("exc_epc", obs_dout, 32'h0000_300C);
    rd(5'd13, 0); check("exc_cause", obs_dout, 32'h8000_0030);

    // requests ignored in handler
    step(0, 0, 5'd12, 0, 32'h0000_5000, 0, 5'd4, 6'h3F, 0);
    check("hdl_noentry", {31'd0, obs_to}, 32'd0);
    check("hdl_sr", obs_dout, 32'h0000_FC03);
    rd(5'd13, 6'h3F); check("hdl_cause_ip", obs_dout, 32'h8000_FC30);
    rd(5'd14, 6'd0); check("hdl_epc", obs_dout, 32'h0000_300C);

    // mtc0 EPC forwarded to same-slot ERET
    step(0, 1, 5'd14, 32'h0000_3023, 0, 0, 5'd0, 6'd0, 1);
    check("fwd_back", {31'd0, obs_back}, 32'd1);
    check("fwd_epc", obs_epc, 32'h0000_3020);
    rd(5'd12, 0); check("fwd_sr", obs_dout, 32'h0000_FC01);
    rd(5'd14, 0); check("fwd_epcreg", obs_dout, 32'h0000_3020);

    // level interrupt held through ERET re-fires one cycle later
    step(0, 0, 5'd0, 0, 32'h0000_0100, 0, 5'd0, 6'b000001, 0);
    step(0, 0, 5'd0, 0, 32'h0000_0104, 0, 5'd0, 6'b000001, 1);
    check("lvl_eret_to", {31'd0, obs_to}, 32'd0);
    check("lvl_eret_back", {31'd0, obs_back}, 32'd1);
    step(0, 0, 5'd0, 0, 32'h0000_4180, 0, 5'd0, 6'b000001, 0);
    check("lvl_refire", {31'd0, obs_to}, 32'd1);
    step(0, 0, 5'd0, 0, 0, 0, 5'd0, 6'd0, 1);

    // illegal ERET colliding with exception: entry wins; also bd with pc 0 wraps
    step(0, 0, 5'd0, 0, 32'h0000_0000, 1, 5'd5, 6'd0, 1);
    check("coll_to", {31'd0, obs_to}, 32'd1);
    check("coll_back", {31'd0, obs_back}, 32'd0);
    rd(5'd14, 0); check("wrap_epc", obs_dout, 32'hFFFF_FFFC);

    // reset mid-handler
    step(1, 0, 5'd12, 0, 0, 0, 5'd4, 6'h3F, 1);
    check("rst_to", {31'd0, obs_to}, 32'd0);
    check("rst_back", {31'd0, obs_back}, 32'd0);
    rd(5'd12, 0); check("rst_sr", obs_dout, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rw  = ($urandom_range(3) == 0);
      ra  = ($urandom_range(4) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(15, 12));
      rec = ($urandom_range(9) < 7) ? 5'd0 : 5'($urandom_range(31, 1));
      rhw = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'd0;
      rer = ($urandom_range(7) == 0);
      if (rw && ra == 5'd12) rer = 1'b0;
      step(($urandom_range(63) == 0), rw, ra, $urandom, $urandom, 1'($urandom_range(1)),
           rec, rhw, rer);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
